// File: rtl/univ_ff_pkg.sv
// Shared mode encoding for the universal flip-flop bank.
package univ_ff_pkg;

   typedef logic [1:0] ff_mode_t;

   localparam ff_mode_t MODE_D  = 2'b00;
   localparam ff_mode_t MODE_T  = 2'b01;
   localparam ff_mode_t MODE_JK = 2'b10;
   localparam ff_mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK storage cell with synchronous reset to a per-bit init value.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic init,
   input  logic j,
   input  logic k,
   output logic q
);

   // JK excitation: 00 hold, 01 clear, 10 set, 11 toggle; reset wins over enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= init;
      end else if (en) begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/univ_ff_bank.sv
// WIDTH-bit register bank of JK cells whose excitation mode (D, T, JK, SR)
// is selected at runtime through a loadable mode register. Also tracks a
// one-cycle mask of flipped bits and a sticky flag for invalid SR inputs.
module univ_ff_bank
   import univ_ff_pkg::*;
#(
   parameter int             WIDTH      = 8,
   parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
   parameter logic [1:0]     RESET_MODE = 2'b00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode_ld,
   input  logic [1:0]       mode_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [1:0]       mode_q,
   output logic [WIDTH-1:0] changed,
   output logic             sr_err
);

   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q_next;
   logic             sr_bad;

   // Mode register: loads independently of en, so data on the load edge
   // still sees the previous mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= RESET_MODE;
      end else if (mode_ld) begin
         mode_q <= mode_in;
      end
   end

   // Map (a, b) onto per-bit J/K according to the active mode.
   always_comb begin
      j = '0;
      k = '0;
      case (ff_mode_t'(mode_q))
         MODE_D:  begin j = a;      k = ~a;     end
         MODE_T:  begin j = a;      k = a;      end
         MODE_JK: begin j = a;      k = b;      end
         default: begin j = a & ~b; k = b & ~a; end
      endcase
   end

   // Next-state preview used only for the change mask; mirrors the cell rule.
   always_comb begin
      q_next = (q & ~k) | (~q & j);
   end

   // Any S=R=1 bit in SR mode is an invalid request (the bit holds).
   always_comb begin
      sr_bad = (ff_mode_t'(mode_q) == MODE_SR) && ((a & b) != '0);
   end

   // Storage cells.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .init (INIT[i]),
         .j    (j[i]),
         .k    (k[i]),
         .q    (q[i])
      );
   end

   assign qn = ~q;

   // Change mask is valid for one cycle after an enabled edge, zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         changed <= '0;
      end else if (en) begin
         changed <= q_next ^ q;
      end else begin
         changed <= '0;
      end
   end

   // Sticky invalid-SR flag: set beats clear on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_err <= 1'b0;
      end else if (en && sr_bad) begin
         sr_err <= 1'b1;
      end else if (err_clr) begin
         sr_err <= 1'b0;
      end
   end

endmodule
